// File: rtl/reg_file_param_if.sv
// Decode-stage register file port bundle: two read ports, one write port, clear status.
// The master drives addresses and write data; the slave returns read data and status.
interface reg_file_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wea;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              ready;
    logic              clr_busy;

    modport master (
        output raddr1, raddr2, waddr, wdata, wea,
        input  rdata1, rdata2, ready, clr_busy
    );

    modport slave (
        input  raddr1, raddr2, waddr, wdata, wea,
        output rdata1, rdata2, ready, clr_busy
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised decode-stage register file with a reset-time clear sequencer,
// optional hardwired zero entry, optional write bypass and optional registered reads.
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter bit READ_REG = 1'b0
) (
    input  logic                 clk_n,
    input  logic                 rst_n,
    reg_file_param_if.slave      bus
);
    localparam int unsigned       DEPTH    = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_idx_r;
    logic              ready_r;
    logic              clr_busy_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              write_ok_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // Clear sequencer: walks every entry once after reset, then opens the file.
    always_ff @(posedge clk_n) begin
        if (!rst_n) begin
            state_r    <= CLEAR;
            clr_idx_r  <= '0;
            ready_r    <= 1'b0;
            clr_busy_r <= 1'b1;
        end else begin
            case (state_r)
                CLEAR: begin
                    clr_idx_r <= clr_idx_r + ONE_IDX;
                    if (clr_idx_r == LAST_IDX) begin
                        state_r    <= READY;
                        ready_r    <= 1'b1;
                        clr_busy_r <= 1'b0;
                    end else begin
                        state_r    <= CLEAR;
                        ready_r    <= 1'b0;
                        clr_busy_r <= 1'b1;
                    end
                end
                READY: begin
                    state_r    <= READY;
                    ready_r    <= 1'b1;
                    clr_busy_r <= 1'b0;
                end
                default: begin
                    state_r    <= CLEAR;
                    clr_idx_r  <= '0;
                    ready_r    <= 1'b0;
                    clr_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // A write lands only once the file is open, and never into a hardwired zero entry.
    always_comb begin
        write_ok_s = 1'b0;
        if (ready_r && bus.wea && !(ZERO_REG && (bus.waddr == '0))) begin
            write_ok_s = 1'b1;
        end else begin
            write_ok_s = 1'b0;
        end
    end

    // Storage array; left untouched while reset is held, writes from writeback dropped during clear.
    always_ff @(posedge clk_n) begin
        if (rst_n) begin
            if (state_r == CLEAR) begin
                mem_r[clr_idx_r] <= '0;
            end else if (write_ok_s) begin
                mem_r[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Read port 1 selection: zero entry, then forwarded write data, then stored value.
    always_comb begin
        rd1_s = '0;
        if (!ready_r) begin
            rd1_s = '0;
        end else if (ZERO_REG && (bus.raddr1 == '0)) begin
            rd1_s = '0;
        end else if (BYPASS && write_ok_s && (bus.raddr1 == bus.waddr)) begin
            rd1_s = bus.wdata;
        end else begin
            rd1_s = mem_r[bus.raddr1];
        end
    end

    // Read port 2 selection, same precedence as port 1.
    always_comb begin
        rd2_s = '0;
        if (!ready_r) begin
            rd2_s = '0;
        end else if (ZERO_REG && (bus.raddr2 == '0)) begin
            rd2_s = '0;
        end else if (BYPASS && write_ok_s && (bus.raddr2 == bus.waddr)) begin
            rd2_s = bus.wdata;
        end else begin
            rd2_s = mem_r[bus.raddr2];
        end
    end

    generate
        if (READ_REG) begin : g_read_reg
            logic [DATA_W-1:0] rdata1_r;
            logic [DATA_W-1:0] rdata2_r;

            // Registered read path: operand appears one posedge after the address.
            always_ff @(posedge clk_n) begin
                if (!rst_n) begin
                    rdata1_r <= '0;
                    rdata2_r <= '0;
                end else begin
                    rdata1_r <= rd1_s;
                    rdata2_r <= rd2_s;
                end
            end

            assign bus.rdata1 = rdata1_r;
            assign bus.rdata2 = rdata2_r;
        end else begin : g_read_comb
            assign bus.rdata1 = rd1_s;
            assign bus.rdata2 = rd2_s;
        end
    endgenerate

    assign bus.ready    = ready_r;
    assign bus.clr_busy = clr_busy_r;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: four instances cover the default build,
// no-bypass, registered reads and a 32-bit x 32-entry build.
module tb_reg_file_param;
    logic clk_n;
    logic rst_n;

    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        wea;

    logic [4:0]  w_raddr1;
    logic [4:0]  w_raddr2;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        w_wea;

    int checks;
    int failures;

    reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) if_def ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) if_nb ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) if_rr ();
    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) if_w ();

    assign if_def.raddr1 = raddr1;
    assign if_def.raddr2 = raddr2;
    assign if_def.waddr  = waddr;
    assign if_def.wdata  = wdata;
    assign if_def.wea    = wea;
    assign if_nb.raddr1  = raddr1;
    assign if_nb.raddr2  = raddr2;
    assign if_nb.waddr   = waddr;
    assign if_nb.wdata   = wdata;
    assign if_nb.wea     = wea;
    assign if_rr.raddr1  = raddr1;
    assign if_rr.raddr2  = raddr2;
    assign if_rr.waddr   = waddr;
    assign if_rr.wdata   = wdata;
    assign if_rr.wea     = wea;
    assign if_w.raddr1   = w_raddr1;
    assign if_w.raddr2   = w_raddr2;
    assign if_w.waddr    = w_waddr;
    assign if_w.wdata    = w_wdata;
    assign if_w.wea      = w_wea;

    reg_file_param u_def (.clk_n(clk_n), .rst_n(rst_n), .bus(if_def.slave));
    reg_file_param #(.BYPASS(1'b0)) u_nb (.clk_n(clk_n), .rst_n(rst_n), .bus(if_nb.slave));
    reg_file_param #(.READ_REG(1'b1)) u_rr (.clk_n(clk_n), .rst_n(rst_n), .bus(if_rr.slave));
    reg_file_param #(.DATA_W(32), .ADDR_W(5)) u_w (.clk_n(clk_n), .rst_n(rst_n), .bus(if_w.slave));

    initial clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_n);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        raddr1 = 3'd0; raddr2 = 3'd0; waddr = 3'd0; wdata = 16'h0000; wea = 1'b0;
        w_raddr1 = 5'd0; w_raddr2 = 5'd0; w_waddr = 5'd0; w_wdata = 32'h0; w_wea = 1'b0;

        tick();
        tick();
        check_eq("rst_ready", 32'(if_def.ready), 32'd0);
        check_eq("rst_busy", 32'(if_def.clr_busy), 32'd1);
        check_eq("rst_rr_rdata1", 32'(if_rr.rdata1), 32'd0);

        // Release reset; a write attempted during clear must be dropped.
        rst_n = 1'b1;
        wea = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr1 = 3'd3;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("clr_rdata1", 32'(if_def.rdata1), 32'd0);
            tick();
            check_eq("clr_ready", 32'(if_def.ready), (i == 7) ? 32'd1 : 32'd0);
        end
        wea = 1'b0;
        check_eq("clr_busy_low", 32'(if_def.clr_busy), 32'd0);
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a); raddr2 = 3'(a);
            #1;
            check_eq("clr_entry_p1", 32'(if_def.rdata1), 32'd0);
            check_eq("clr_entry_p2", 32'(if_def.rdata2), 32'd0);
            tick();
        end

        // Zero register: write to entry 0 is dropped, entry 5 is kept.
        wea = 1'b1; waddr = 3'd0; wdata = 16'h1234; raddr1 = 3'd0;
        #1;
        check_eq("zero_same_cycle", 32'(if_def.rdata1), 32'd0);
        tick();
        wea = 1'b0;
        #1;
        check_eq("zero_after", 32'(if_def.rdata1), 32'd0);
        wea = 1'b1; waddr = 3'd5; wdata = 16'h1234; raddr2 = 3'd5;
        #1;
        check_eq("nb_old_e5", 32'(if_nb.rdata2), 32'd0);
        tick();
        wea = 1'b0;
        #1;
        check_eq("def_e5", 32'(if_def.rdata2), 32'h1234);
        check_eq("nb_e5", 32'(if_nb.rdata2), 32'h1234);

        // Bypass on combinational reads; no-bypass build shows old data until next cycle.
        wea = 1'b1; waddr = 3'd2; wdata = 16'hA5A5; raddr1 = 3'd2; raddr2 = 3'd2;
        #1;
        check_eq("byp_p1", 32'(if_def.rdata1), 32'hA5A5);
        check_eq("byp_p2", 32'(if_def.rdata2), 32'hA5A5);
        check_eq("nobyp_old", 32'(if_nb.rdata1), 32'd0);
        tick();
        wea = 1'b0;
        #1;
        check_eq("nobyp_new", 32'(if_nb.rdata1), 32'hA5A5);

        // Registered reads: one posedge of latency, bypass seen on the following cycle.
        wea = 1'b1; waddr = 3'd4; wdata = 16'h00FF; raddr1 = 3'd0;
        tick();
        wea = 1'b0; raddr1 = 3'd4;
        #1;
        check_eq("rr_not_before", 32'(if_rr.rdata1), 32'd0);
        tick();
        check_eq("rr_latency", 32'(if_rr.rdata1), 32'h00FF);
        wea = 1'b1; waddr = 3'd4; wdata = 16'h0F0F;
        #1;
        check_eq("rr_hold", 32'(if_rr.rdata1), 32'h00FF);
        tick();
        wea = 1'b0;
        #1;
        check_eq("rr_bypass", 32'(if_rr.rdata1), 32'h0F0F);

        // Fill some entries with all-ones, then reset in the middle of the clear.
        for (int a = 1; a < 8; a++) begin
            wea = 1'b1; waddr = 3'(a); wdata = 16'hFFFF;
            tick();
        end
        wea = 1'b0; raddr1 = 3'd7;
        #1;
        check_eq("ffff_written", 32'(if_def.rdata1), 32'hFFFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("mid_ready", 32'(if_def.ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i < 9) begin
                check_eq("mid_def_ready", 32'(if_def.ready), (i >= 7) ? 32'd1 : 32'd0);
            end
            if (i >= 30) begin
                check_eq("wide_ready", 32'(if_w.ready), (i == 31) ? 32'd1 : 32'd0);
            end
        end
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a); raddr2 = 3'(a);
            #1;
            check_eq("mid_entry", 32'(if_def.rdata1), 32'd0);
            tick();
        end

        // Wide build: 32-bit data, 32 entries, entry 0 hardwired.
        w_wea = 1'b1; w_wdata = 32'hDEADBEEF;
        w_waddr = 5'd0;
        tick();
        w_waddr = 5'd31;
        tick();
        w_waddr = 5'd1;
        tick();
        w_wea = 1'b0; w_raddr1 = 5'd31; w_raddr2 = 5'd1;
        #1;
        check_eq("wide_e31", if_w.rdata1, 32'hDEADBEEF);
        check_eq("wide_e1", if_w.rdata2, 32'hDEADBEEF);
        w_raddr1 = 5'd0; w_raddr2 = 5'd30;
        #1;
        check_eq("wide_e0", if_w.rdata1, 32'd0);
        check_eq("wide_e30", if_w.rdata2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
